button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage for the maze state machine.
- Takes the three raw board push-buttons (left, centre, right) and, per button:
  - synchronises it to CLK,
  - debounces it,
  - emits a clean debounced level plus a single-cycle press pulse.
- The pulses drive the state machine's BTN_LEFT/BTN_CENTRE/BTN_RIGHT inputs, so each physical press advances the state machine exactly once.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz). Legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-channel debounce counter. Derived; not to be overridden.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
- BTN_LEFT_RAW  input  1  raw, asynchronous left button
- BTN_CENTRE_RAW  input  1  raw, asynchronous centre button
- BTN_RIGHT_RAW  input  1  raw, asynchronous right button
- BTN_LEFT  output  1  one-cycle pulse on accepted left press
- BTN_CENTRE  output  1  one-cycle pulse on accepted centre press
- BTN_RIGHT  output  1  one-cycle pulse on accepted right press
- BTN_LEVEL  output  3  debounced levels {left, centre, right}; bit 2 = left

Behaviour:
- Reset (RESET low, asynchronous):
  - all synchroniser flops cleared to 0;
  - all channels in IDLE with counter 0;
  - BTN_LEFT/CENTRE/RIGHT = 0; BTN_LEVEL = 3'b000.
  - Reset takes effect immediately and overrides any in-progress count.
- Synchroniser: two flops per channel (sync1, sync2). Only sync2 feeds the FSM.
- Per-channel FSM. States: IDLE (stable low), PRESS_WAIT, PRESSED (stable high), RELEASE_WAIT.
  - IDLE: if sync2=1 -> PRESS_WAIT, cnt<=0; otherwise hold.
  - PRESS_WAIT:
    - if sync2=0 -> IDLE, cnt<=0; no pulse.
    - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and pulse<=1.
    - else cnt<=cnt+1.
  - PRESSED: if sync2=0 -> RELEASE_WAIT, cnt<=0; otherwise hold.
  - RELEASE_WAIT:
    - if sync2=1 -> PRESSED, cnt<=0.
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt<=cnt+1.
    - No pulse on release.
- Outputs:
  - pulse is registered and high for exactly one cycle: the first cycle in PRESSED after PRESS_WAIT. No pulse on the RELEASE_WAIT->PRESSED bounce return.
  - BTN_LEVEL bit = 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- Latency, with raw held steady:
  - pulse and level rise are visible after rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples raw=1 as edge 1. This is 2 edges of synchroniser, 1 edge to enter PRESS_WAIT, then DEBOUNCE_CYCLES edges.
  - Level fall takes the same DEBOUNCE_CYCLES+3 edges after release.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. DEBOUNCE_CYCLES=1 gives a transition on the first wait cycle.
- Channels are fully independent:
  - simultaneous presses give simultaneous pulses;
  - no priority or mutual exclusion is imposed here. The state machine handles that.
- Holding a button: one pulse only, no auto-repeat.
- Button held through reset release: treated as a new press; pulse after DEBOUNCE_CYCLES+3 edges from reset deassertion.
- Bounce shorter than DEBOUNCE_CYCLES stable samples is fully rejected.

Decomposition:
- Shared package/include button_pkg:
  - 2-bit state encodings IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3;
  - default DEBOUNCE_CYCLES constant;
  - BTN_LEVEL bit-index constants LEFT=2, CENTRE=1, RIGHT=0.
- One sub-module debounce_channel:
  - contents: synchroniser, counter, FSM, pulse and level for a single button;
  - ports CLK, RESET, RAW, PULSE, LEVEL; parameter DEBOUNCE_CYCLES.
- button_conditioner instantiates debounce_channel three times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset state: assert RESET=0 mid-count with LEFT raw high -> all pulses 0 and BTN_LEVEL=000 immediately, before the next CLK edge.
- Clean press: LEFT raw 0->1 held -> BTN_LEFT high for exactly one cycle after edge 7; BTN_LEVEL=100 from edge 7. No further pulse while held 50 cycles.
- Bounce reject: CENTRE raw high 3 cycles, low 1, high 2, low -> no BTN_CENTRE pulse; BTN_LEVEL stays 000.
- Release with bounce: RIGHT in PRESSED, raw low 2 cycles then high 1 -> no pulse, BTN_LEVEL[0] stays 1. Raw then low steady -> BTN_LEVEL[0]=0 after 7 edges.
- Simultaneous: LEFT and RIGHT raw rise on the same cycle -> BTN_LEFT and BTN_RIGHT pulse on the same cycle; BTN_LEVEL=101.
- Held through reset: CENTRE raw high, RESET pulsed low then high -> single BTN_CENTRE pulse 7 edges after RESET deasserts.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: channel state encoding,
// the default debounce interval and the bit positions inside BTN_LEVEL.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  localparam int LEFT   = 2;
  localparam int CENTRE = 1;
  localparam int RIGHT  = 0;

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stable-sample counter and a four-state
// debounce FSM producing a clean level and a single-cycle press pulse.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RAW,
  output logic PULSE,
  output logic LEVEL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Bring the asynchronous button into the clock domain; only sync2 is used.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= RAW;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive stable
  // samples; any disagreement returns to the previous stable state and the
  // pulse is raised only on the PRESS_WAIT -> PRESSED step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign PULSE = pulse_q;
  assign LEVEL = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three board push-buttons for the maze state machine. Each
// channel is independent; no priority is applied between buttons here.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_LEFT_RAW,
  input  logic       BTN_CENTRE_RAW,
  input  logic       BTN_RIGHT_RAW,
  output logic       BTN_LEFT,
  output logic       BTN_CENTRE,
  output logic       BTN_RIGHT,
  output logic [2:0] BTN_LEVEL
);

  logic levelLeft;
  logic levelCentre;
  logic levelRight;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLeft (
    .CLK   (CLK),
    .RESET (RESET),
    .RAW   (BTN_LEFT_RAW),
    .PULSE (BTN_LEFT),
    .LEVEL (levelLeft)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uCentre (
    .CLK   (CLK),
    .RESET (RESET),
    .RAW   (BTN_CENTRE_RAW),
    .PULSE (BTN_CENTRE),
    .LEVEL (levelCentre)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRight (
    .CLK   (CLK),
    .RESET (RESET),
    .RAW   (BTN_RIGHT_RAW),
    .PULSE (BTN_RIGHT),
    .LEVEL (levelRight)
  );

  // Pack the debounced levels into their fixed bit positions.
  always_comb begin
    BTN_LEVEL         = 3'b000;
    BTN_LEVEL[LEFT]   = levelLeft;
    BTN_LEVEL[CENTRE] = levelCentre;
    BTN_LEVEL[RIGHT]  = levelRight;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4, so a steady
// press or release is accepted on the 7th clock edge after it is applied.
// Observed vector is {BTN_LEFT, BTN_CENTRE, BTN_RIGHT, BTN_LEVEL[2:0]}.
module tb_button_conditioner;

  logic       CLK;
  logic       RESET;
  logic       BTN_LEFT_RAW;
  logic       BTN_CENTRE_RAW;
  logic       BTN_RIGHT_RAW;
  logic       BTN_LEFT;
  logic       BTN_CENTRE;
  logic       BTN_RIGHT;
  logic [2:0] BTN_LEVEL;

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BTN_LEFT_RAW   (BTN_LEFT_RAW),
    .BTN_CENTRE_RAW (BTN_CENTRE_RAW),
    .BTN_RIGHT_RAW  (BTN_RIGHT_RAW),
    .BTN_LEFT       (BTN_LEFT),
    .BTN_CENTRE     (BTN_CENTRE),
    .BTN_RIGHT      (BTN_RIGHT),
    .BTN_LEVEL      (BTN_LEVEL)
  );

  // 100 MHz clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic l, input logic c, input logic r);
    BTN_LEFT_RAW   = l;
    BTN_CENTRE_RAW = c;
    BTN_RIGHT_RAW  = r;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {BTN_LEFT, BTN_CENTRE, BTN_RIGHT, BTN_LEVEL};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [5:0] expected);
    tick();
    checkOutput(tag, expected);
  endtask

  initial begin
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_idle", 6'b000_000);
    RESET = 1'b1;
    stepCheck("post_reset_idle", 6'b000_000);

    // Clean LEFT press: pulse on edge 7 only, level held, no repeat.
    $display("[TB] clean left press");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) stepCheck("left_wait", 6'b000_000);
    stepCheck("left_pulse", 6'b100_100);
    stepCheck("left_pulse_end", 6'b000_100);
    for (int i = 0; i < 50; i++) stepCheck("left_held", 6'b000_100);

    // LEFT release: level drops on edge 7.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) stepCheck("left_release_wait", 6'b000_100);
    stepCheck("left_released", 6'b000_000);

    // CENTRE bounce: high 3, low 1, high 2, low -> fully rejected.
    $display("[TB] centre bounce reject");
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) stepCheck("centre_bounce", 6'b000_000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCheck("centre_bounce", 6'b000_000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) stepCheck("centre_bounce", 6'b000_000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) stepCheck("centre_bounce_tail", 6'b000_000);

    // RIGHT press then release with a one-cycle bounce back high.
    $display("[TB] right release bounce");
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) stepCheck("right_wait", 6'b000_000);
    stepCheck("right_pulse", 6'b001_001);
    stepCheck("right_pulse_end", 6'b000_001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) stepCheck("right_rel_bounce", 6'b000_001);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCheck("right_rel_bounce", 6'b000_001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) stepCheck("right_release_wait", 6'b000_001);
    stepCheck("right_released", 6'b000_000);
    for (int i = 0; i < 3; i++) stepCheck("right_idle", 6'b000_000);

    // LEFT and RIGHT together pulse on the same cycle.
    $display("[TB] simultaneous left+right");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) stepCheck("simul_wait", 6'b000_000);
    stepCheck("simul_pulse", 6'b101_101);
    stepCheck("simul_pulse_end", 6'b000_101);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) stepCheck("simul_release_wait", 6'b000_101);
    stepCheck("simul_released", 6'b000_000);

    // LEFT and CENTRE pressed, then reset asserted mid-count.
    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) stepCheck("midcount_wait", 6'b000_000);
    RESET = 1'b0;
    #1;
    checkOutput("reset_midcount_immediate", 6'b000_000);
    for (int i = 0; i < 4; i++) stepCheck("reset_midcount_hold", 6'b000_000);
    RESET = 1'b1;
    for (int i = 1; i <= 6; i++) stepCheck("lc_wait", 6'b000_000);
    stepCheck("lc_pulse", 6'b110_110);
    stepCheck("lc_pulse_end", 6'b000_110);

    // Reset while levels are high clears them before the next edge.
    $display("[TB] reset while pressed, centre held through reset");
    applyStimulus(1'b0, 1'b1, 1'b0);
    RESET = 1'b0;
    #1;
    checkOutput("reset_pressed_immediate", 6'b000_000);
    for (int i = 0; i < 3; i++) stepCheck("reset_pressed_hold", 6'b000_000);
    RESET = 1'b1;
    for (int i = 1; i <= 6; i++) stepCheck("centre_held_wait", 6'b000_000);
    stepCheck("centre_held_pulse", 6'b010_010);
    for (int i = 0; i < 10; i++) stepCheck("centre_held_no_repeat", 6'b000_010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
